// File: rtl/sc_screen_pkg.sv
// Shared definitions for the LED-matrix screen sequencers and display register banks.
package sc_screen_pkg;

    localparam int unsigned ROWS    = 8;
    localparam int unsigned ROW_W   = 3;
    localparam int unsigned BLINK_W = 8;

    localparam logic [63:0] LOSE_PATTERN  = 64'h0024_2424_003C_4200;
    localparam logic [63:0] CRASH_PATTERN = 64'h8142_2418_1824_4281;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        BLINK_OFF = 3'd2,
        BLINK_ON  = 3'd3,
        HOLD      = 3'd4,
        CLEAR     = 3'd5
    } state_t;

    // Row r of a pattern is byte r, row 7 being the most significant byte.
    function automatic logic [7:0] pattern_row(input logic [63:0] pattern,
                                               input logic [ROW_W-1:0] row);
        return pattern[{row, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sc_tick_prescaler.sv
// Blink half-period prescaler: counts 0..BLINK_TICKS-1, tick_c on the last count.
module sc_tick_prescaler #(
    parameter int unsigned CNT_W       = 25,
    parameter int unsigned BLINK_TICKS = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick_c
);

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_W'(BLINK_TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sc_lose_screen_ctrl.sv
// End-of-game LOSE screen sequencer: load pattern, blink, hold, clear on restart.
// Blink phase is built only when SC_LOSECTRL_BLINK_EN is defined.
module sc_lose_screen_ctrl
    import sc_screen_pkg::*;
#(
    parameter logic [63:0] PATTERN     = LOSE_PATTERN,
    parameter int unsigned BLINK_TICKS = 25_000_000,
    parameter int unsigned BLINK_COUNT = 3,
    parameter int unsigned CNT_W       = 25
) (
    input  logic             SC_LOSECTRL_CLOCK_50,
    input  logic             SC_LOSECTRL_RESET_InLow,
    input  logic             SC_LOSECTRL_CRASH_InLow,
    input  logic             SC_LOSECTRL_RESTART_InLow,
    output logic             SC_LOSECTRL_LOAD_OutLow,
    output logic [ROW_W-1:0] SC_LOSECTRL_ROWSEL_Out,
    output logic [7:0]       SC_LOSECTRL_DATA_Out,
    output logic             SC_LOSECTRL_BLANK_OutLow,
    output logic             SC_LOSECTRL_GAMEOVER_Out,
    output logic             SC_LOSECTRL_DONE_Out
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    if (CNT_W == 0 || CNT_W > 32 || BLINK_TICKS == 0 ||
        BLINK_COUNT >= (32'd1 << BLINK_W) ||
        (64'(BLINK_TICKS) - 64'd1) >= (64'd1 << CNT_W)) begin : g_param_check
        $error("sc_lose_screen_ctrl: blink parameters out of range");
    end

    state_t           state, state_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic             crash_prev;
    logic             crash_edge;
    logic             restart_req;
    logic             load_n_nxt;
    logic [ROW_W-1:0] rowsel_nxt;
    logic [7:0]       data_nxt;
    logic             gameover_nxt;
    logic             done_nxt;
    logic             blank_n_nxt;

    assign crash_edge  = crash_prev & ~SC_LOSECTRL_CRASH_InLow;
    assign restart_req = ~SC_LOSECTRL_RESTART_InLow;

`ifdef SC_LOSECTRL_BLINK_EN
    logic               tick_c;
    logic               prescale_clear;
    logic [BLINK_W-1:0] blink, blink_nxt;

    assign prescale_clear = (state_nxt != state);

    sc_tick_prescaler #(
        .CNT_W       (CNT_W),
        .BLINK_TICKS (BLINK_TICKS)
    ) u_prescaler (
        .clk    (SC_LOSECTRL_CLOCK_50),
        .rst_n  (SC_LOSECTRL_RESET_InLow),
        .clear  (prescale_clear),
        .tick_c (tick_c)
    );
`else
    assign SC_LOSECTRL_BLANK_OutLow = 1'b1;
`endif

    // Next state plus the output values that go with it, so outputs land with the state.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
`ifdef SC_LOSECTRL_BLINK_EN
        blink_nxt = blink;
`endif
        case (state)
            IDLE: begin
                if (crash_edge) begin
                    state_nxt = LOAD;
                    row_nxt   = '0;
                end
            end
            LOAD: begin
`ifdef SC_LOSECTRL_BLINK_EN
                blink_nxt = '0;
`endif
                if (row == LAST_ROW) begin
`ifdef SC_LOSECTRL_BLINK_EN
                    if (BLINK_COUNT == 0) state_nxt = HOLD;
                    else                  state_nxt = BLINK_OFF;
`else
                    state_nxt = HOLD;
`endif
                end else begin
                    row_nxt = row + ROW_W'(1);
                end
            end
`ifdef SC_LOSECTRL_BLINK_EN
            BLINK_OFF: begin
                if (restart_req) begin
                    state_nxt = CLEAR;
                    row_nxt   = '0;
                end else if (tick_c) begin
                    state_nxt = BLINK_ON;
                end
            end
            BLINK_ON: begin
                if (restart_req) begin
                    state_nxt = CLEAR;
                    row_nxt   = '0;
                end else if (tick_c) begin
                    blink_nxt = blink + BLINK_W'(1);
                    if (blink_nxt == BLINK_W'(BLINK_COUNT)) state_nxt = HOLD;
                    else                                    state_nxt = BLINK_OFF;
                end
            end
`endif
            HOLD: begin
                if (restart_req) begin
                    state_nxt = CLEAR;
                    row_nxt   = '0;
                end
            end
            CLEAR: begin
                if (row == LAST_ROW) state_nxt = IDLE;
                else                 row_nxt   = row + ROW_W'(1);
            end
            default: begin
                state_nxt = IDLE;
                row_nxt   = '0;
            end
        endcase

        gameover_nxt = (state_nxt != IDLE);
        done_nxt     = (state_nxt == HOLD) && (state != HOLD);
        load_n_nxt   = !((state_nxt == LOAD) || (state_nxt == CLEAR));
        rowsel_nxt   = load_n_nxt ? '0 : row_nxt;
        data_nxt     = (state_nxt == LOAD) ? pattern_row(PATTERN, row_nxt) : 8'h00;
        blank_n_nxt  = (state_nxt != BLINK_OFF);
    end

    always_ff @(posedge SC_LOSECTRL_CLOCK_50 or negedge SC_LOSECTRL_RESET_InLow) begin
        if (!SC_LOSECTRL_RESET_InLow) begin
            state                    <= IDLE;
            row                      <= '0;
            crash_prev               <= 1'b1;
            SC_LOSECTRL_LOAD_OutLow  <= 1'b1;
            SC_LOSECTRL_ROWSEL_Out   <= '0;
            SC_LOSECTRL_DATA_Out     <= 8'h00;
            SC_LOSECTRL_GAMEOVER_Out <= 1'b0;
            SC_LOSECTRL_DONE_Out     <= 1'b0;
`ifdef SC_LOSECTRL_BLINK_EN
            blink                    <= '0;
            SC_LOSECTRL_BLANK_OutLow <= 1'b1;
`endif
        end else begin
            state                    <= state_nxt;
            row                      <= row_nxt;
            crash_prev               <= SC_LOSECTRL_CRASH_InLow;
            SC_LOSECTRL_LOAD_OutLow  <= load_n_nxt;
            SC_LOSECTRL_ROWSEL_Out   <= rowsel_nxt;
            SC_LOSECTRL_DATA_Out     <= data_nxt;
            SC_LOSECTRL_GAMEOVER_Out <= gameover_nxt;
            SC_LOSECTRL_DONE_Out     <= done_nxt;
`ifdef SC_LOSECTRL_BLINK_EN
            blink                    <= blink_nxt;
            SC_LOSECTRL_BLANK_OutLow <= blank_n_nxt;
`endif
        end
    end

`ifndef SC_LOSECTRL_BLINK_EN
    logic unused_blank;
    assign unused_blank = blank_n_nxt;
`endif

endmodule
